// File: rtl/test_tx_pkg.sv
// Shared definitions for the test-pattern transmitter and its receive checker.
// Holds the FSM encoding, the default scrambler seed, the frame-length clamp
// and the scrambler word-advance function so both ends step identically.
package test_tx_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEED = 2'd1;
    localparam logic [1:0] ST_TX   = 2'd2;
    localparam logic [1:0] ST_GAP  = 2'd3;

    localparam logic [15:0] C_SCR_INIT = 16'h55AA;
    localparam int          C_LEN_MIN  = 2;

    // One scrambler word = 16 serial shifts of x^16+x^15+x^13+x^4+1.
    function automatic logic [15:0] scr_next(input logic [15:0] s);
        logic [15:0] r;
        r = s;
        for (int i = 0; i < 16; i++) begin
            r = {r[14:0], r[15] ^ r[14] ^ r[12] ^ r[3]};
        end
        return r;
    endfunction

    function automatic logic [15:0] clamp_len(input logic [15:0] len, input int min_len);
        return ({16'd0, len} < 32'(min_len)) ? 16'(min_len) : len;
    endfunction

endpackage

// File: rtl/sata_scrambler.sv
// Purpose: 16-bit LFSR pattern source; word 0 after sof is the seed itself.
// Latency: output is the current word; reseed/advance take effect next cycle.
// Backpressure: advances only when p_in_en is high, otherwise holds the word.
// Ports: clk/rst, p_in_sof (reload seed), p_in_en (advance), p_out_data (word).
module sata_scrambler
    import test_tx_pkg::*;
#(
    parameter logic [15:0] G_INIT = C_SCR_INIT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        p_in_sof,
    input  logic        p_in_en,
    output logic [15:0] p_out_data
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_out_data <= G_INIT;
        end else if (p_in_sof) begin
            p_out_data <= G_INIT;
        end else if (p_in_en) begin
            p_out_data <= scr_next(p_out_data);
        end
    end

endmodule

// File: rtl/test_tx.sv
// Purpose: back-to-back scrambled test frames onto the MAC tx byte interface.
// Latency: start -> seed cycle -> first byte; len bytes + (1+G_IFG) idle per frame.
// Backpressure: byte/sof/eof held while valid && !rdy; scrambler steps on accept only.
// Ports: clk/rst, start, frame_len in; mac_tx_data/valid/sof/eof out, mac_tx_rdy in;
//        busy, frame_done (pulse after eof accept), frame_cnt (wrapping) out.
module test_tx
    import test_tx_pkg::*;
#(
    parameter logic [15:0] G_SCR_INIT = C_SCR_INIT,
    parameter int          G_IFG      = 12,
    parameter int          G_LEN_MIN  = C_LEN_MIN
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] frame_len,
    output logic [7:0]  mac_tx_data,
    output logic        mac_tx_valid,
    output logic        mac_tx_sof,
    output logic        mac_tx_eof,
    input  logic        mac_tx_rdy,
    output logic        busy,
    output logic        frame_done,
    output logic [31:0] frame_cnt
);

    logic [1:0]  state;
    logic [15:0] len;
    logic [15:0] byte_cnt;
    logic [15:0] gap_cnt;
    logic [7:0]  scr_byte;
    logic [7:0]  scr_unused_hi;
    logic        tx_acc;
    logic        last_byte;
    logic        gap_end;

    sata_scrambler #(
        .G_INIT (G_SCR_INIT)
    ) u_scr (
        .clk        (clk),
        .rst        (rst),
        .p_in_sof   (state == ST_SEED),
        .p_in_en    (tx_acc),
        .p_out_data ({scr_unused_hi, scr_byte})
    );

    // valid decodes straight from state so an async reset drops it at once.
    assign mac_tx_valid = (state == ST_TX);
    assign tx_acc       = mac_tx_valid && mac_tx_rdy;
    assign last_byte    = (byte_cnt == len - 16'd1);
    assign mac_tx_data  = mac_tx_valid ? scr_byte : 8'h00;
    assign mac_tx_sof   = mac_tx_valid && (byte_cnt == 16'd0);
    assign mac_tx_eof   = mac_tx_valid && last_byte;
    assign busy         = (state != ST_IDLE);
    assign gap_end      = (gap_cnt == 16'(G_IFG - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            len        <= 16'd0;
            byte_cnt   <= 16'd0;
            gap_cnt    <= 16'd0;
            frame_cnt  <= 32'd0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        len   <= clamp_len(frame_len, G_LEN_MIN);
                        state <= ST_SEED;
                    end
                end
                ST_SEED: begin
                    state <= ST_TX;
                end
                ST_TX: begin
                    if (tx_acc) begin
                        if (last_byte) begin
                            byte_cnt   <= 16'd0;
                            frame_cnt  <= frame_cnt + 32'd1;
                            frame_done <= 1'b1;
                            gap_cnt    <= 16'd0;
                            state      <= ST_GAP;
                        end else begin
                            byte_cnt <= byte_cnt + 16'd1;
                        end
                    end
                end
                ST_GAP: begin
                    // start is only looked at on the last gap cycle.
                    if (gap_end) begin
                        if (start) begin
                            len   <= clamp_len(frame_len, G_LEN_MIN);
                            state <= ST_SEED;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + 16'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_test_tx.sv
// Purpose: self-checking bench for test_tx against a bit-stream reference.
// Latency: n/a (bench).
// Backpressure: mac_tx_rdy driven randomly or held high per scenario.
module tb_test_tx;

    localparam int          IFG  = 12;
    localparam int          LMIN = 2;
    localparam logic [15:0] SEED = 16'h55AA;
    localparam int          NW   = 300;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [15:0] frame_len = 16'd0;
    logic        mac_tx_rdy = 1'b0;
    logic [7:0]  mac_tx_data;
    logic        mac_tx_valid;
    logic        mac_tx_sof;
    logic        mac_tx_eof;
    logic        busy;
    logic        frame_done;
    logic [31:0] frame_cnt;

    test_tx #(
        .G_SCR_INIT (SEED),
        .G_IFG      (IFG),
        .G_LEN_MIN  (LMIN)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .frame_len    (frame_len),
        .mac_tx_data  (mac_tx_data),
        .mac_tx_valid (mac_tx_valid),
        .mac_tx_sof   (mac_tx_sof),
        .mac_tx_eof   (mac_tx_eof),
        .mac_tx_rdy   (mac_tx_rdy),
        .busy         (busy),
        .frame_done   (frame_done),
        .frame_cnt    (frame_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // Reference: byte k of a frame is the low byte of word k, where the
    // scrambler output is one continuous bit stream b[n] = b[n-16]^b[n-15]^b[n-13]^b[n-4]
    // starting from the seed (MSB first) and cut into 16-bit words.
    logic [7:0] exp_byte [NW];
    initial begin : build_ref
        logic        bits [NW*16];
        logic [15:0] sd;
        sd = SEED;
        for (int i = 0; i < 16; i++) bits[i] = sd[15-i];
        for (int n = 16; n < NW*16; n++) bits[n] = bits[n-16] ^ bits[n-15] ^ bits[n-13] ^ bits[n-4];
        for (int k = 0; k < NW; k++)
            for (int j = 0; j < 8; j++) exp_byte[k][7-j] = bits[16*k + 8 + j];
    end

    // Scenario knobs and model state.
    bit          rdy_rand = 1'b0;
    bit          rand_len = 1'b0;
    int          intended_len = 8;
    int          cur_len = 8;
    int          k_exp = 0;
    int          frames_seen = 0;
    int          sof_seen = 0;
    int          idle_run = 0;
    bit          exp_done = 1'b0;
    bit          after_eof = 1'b0;
    bit          hold = 1'b0;
    logic [10:0] hold_vec = '0;

    initial forever begin
        @(posedge clk);
        #1;
        mac_tx_rdy = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor + scoreboard, sampling on the falling edge.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            k_exp = 0; frames_seen = 0; sof_seen = 0; idle_run = 0;
            exp_done = 1'b0; after_eof = 1'b0; hold = 1'b0;
            frame_len = 16'(intended_len);
        end else begin
            if (exp_done || frame_done) begin
                check_val("frame_done", frame_done, exp_done);
                if (exp_done) check_val("frame_cnt_at_done", frame_cnt, 32'(frames_seen));
            end
            exp_done = 1'b0;
            if (hold) check_val("hold_stable", {mac_tx_valid, mac_tx_sof, mac_tx_eof, mac_tx_data}, hold_vec);
            if (k_exp != 0) check_val("in_frame_valid", mac_tx_valid, 1'b1);
            if (mac_tx_valid) begin
                if (k_exp == 0) begin
                    cur_len = (intended_len < LMIN) ? LMIN : intended_len;
                    if (after_eof) check_val("ifg_idle_cycles", idle_run, IFG + 1);
                    after_eof = 1'b0;
                    if (!hold) begin
                        sof_seen++;
                        // length input is junk for the rest of the frame
                        frame_len = 16'($urandom);
                    end
                end
                check_val("byte", {mac_tx_sof, mac_tx_eof, mac_tx_data},
                          {k_exp == 0, k_exp == cur_len - 1, exp_byte[k_exp]});
                if (mac_tx_rdy) begin
                    hold = 1'b0;
                    if (k_exp == cur_len - 1) begin
                        k_exp = 0; frames_seen++; exp_done = 1'b1;
                        after_eof = 1'b1; idle_run = 0;
                        if (rand_len) intended_len = $urandom_range(0, 20);
                        frame_len = 16'(intended_len);
                    end else begin
                        k_exp++;
                    end
                end else begin
                    hold = 1'b1;
                    hold_vec = {mac_tx_valid, mac_tx_sof, mac_tx_eof, mac_tx_data};
                end
            end else begin
                hold = 1'b0;
                idle_run++;
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_outputs", {mac_tx_valid, mac_tx_sof, mac_tx_eof, mac_tx_data, busy, frame_done}, 13'd0);
        check_val("rst_frame_cnt", frame_cnt, 32'd0);
        rst = 1'b0;
    endtask

    task automatic wait_frames(input int n, input int budget, input string tag);
        int c = 0;
        while (frames_seen < n && c < budget) begin
            @(posedge clk);
            c++;
        end
        check_val(tag, frames_seen, n);
    endtask

    task automatic wait_byte(input int idx, input int budget, input string tag);
        int c = 0;
        while (k_exp != idx && c < budget) begin
            @(posedge clk);
            c++;
        end
        check_val(tag, k_exp, idx);
    endtask

    initial begin
        // 1: len 8, no backpressure, identical repeated frames with fixed gap
        do_reset();
        rdy_rand = 1'b0; rand_len = 1'b0;
        intended_len = 8; frame_len = 16'd8; start = 1'b1;
        wait_frames(3, 200, "t1_frames");
        #2 check_val("t1_frame_cnt", frame_cnt, 32'd3);

        // 2: random backpressure, len 64
        do_reset();
        rdy_rand = 1'b1; intended_len = 64; frame_len = 16'd64; start = 1'b1;
        wait_frames(2, 800, "t2_frames");

        // 3: clamped lengths; start toggled inside the gap must not matter
        do_reset();
        rdy_rand = 1'b0; intended_len = 0; frame_len = 16'd0; start = 1'b1;
        wait_frames(1, 100, "t3_len0_first");
        repeat (2) @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #1 start = 1'b1;
        wait_frames(3, 100, "t3_len0_frames");
        do_reset();
        intended_len = 1; frame_len = 16'd1; start = 1'b1;
        wait_frames(2, 100, "t3_len1_frames");

        // 4: start dropped at byte 10 of 32
        do_reset();
        rdy_rand = 1'b1; intended_len = 32; frame_len = 16'd32; start = 1'b1;
        wait_byte(10, 200, "t4_reach_byte10");
        #1 start = 1'b0;
        wait_frames(1, 400, "t4_frames");
        @(negedge clk);
        check_val("t4_busy_gap_start", busy, 1'b1);
        repeat (IFG - 1) @(negedge clk);
        check_val("t4_busy_gap_last", busy, 1'b1);
        @(negedge clk);
        check_val("t4_busy_fall", busy, 1'b0);
        repeat (50) @(posedge clk);
        check_val("t4_no_more_sof", sof_seen, 1);
        check_val("t4_frame_cnt", frame_cnt, 32'd1);

        // 5: async reset at byte 5, then restart from word 0
        do_reset();
        rdy_rand = 1'b0; intended_len = 16; frame_len = 16'd16; start = 1'b1;
        wait_frames(2, 200, "t5_frames_pre");
        wait_byte(5, 100, "t5_reach_byte5");
        #2;
        check_val("t5_valid_pre", mac_tx_valid, 1'b1);
        check_val("t5_cnt_pre", frame_cnt, 32'd2);
        rst = 1'b1;
        #1;
        check_val("t5_valid_async", mac_tx_valid, 1'b0);
        check_val("t5_busy_async", busy, 1'b0);
        check_val("t5_cnt_async", frame_cnt, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        wait_frames(1, 100, "t5_restart_frame");

        // 6: long run, 100 frames of 256
        do_reset();
        rdy_rand = 1'b0; intended_len = 256; frame_len = 16'd256; start = 1'b1;
        wait_frames(100, 100 * (256 + IFG + 1) + 100, "t6_frames");
        #2 check_val("t6_frame_cnt", frame_cnt, 32'd100);

        // 7: random lengths per frame with random backpressure
        do_reset();
        rdy_rand = 1'b1; rand_len = 1'b1;
        intended_len = $urandom_range(0, 20); frame_len = 16'(intended_len); start = 1'b1;
        wait_frames(20, 3000, "t7_frames");
        #2 check_val("t7_frame_cnt", frame_cnt, 32'd20);
        start = 1'b0;
        rand_len = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
